// File: rtl/solar_pkg.sv
// Shared definitions for the solar panel stepper scheduler.
//
// Contents:
//   - default parameter values (steps per hour, day length, step rate, home coil pattern)
//   - derived position-counter width
//   - scheduler state encoding
//   - coil rotation helper used by the phase generator
package solar_pkg;

  localparam int          STEPS_PER_HOUR_DEF = 8;
  localparam int          DAY_HOURS_DEF      = 12;
  localparam int          HOURS_PER_DAY_DEF  = 24;
  localparam int          STEP_DIV_DEF       = 4;
  localparam logic [3:0]  PHASE_INIT_DEF     = 4'b1001;

  // Position ranges 0..DAY_HOURS*STEPS_PER_HOUR inclusive.
  localparam int POS_W_DEF = $clog2(DAY_HOURS_DEF * STEPS_PER_HOUR_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RET  = 2'd2
  } sched_state_t;

  // One full-step of the 4-phase pattern. Forward rotates left,
  // return rotates right, so a return exactly retraces a forward move.
  function automatic logic [3:0] rot_coil(input logic [3:0] c, input logic rev);
    logic [3:0] r;
    if (rev) r = {c[0], c[3:1]};
    else     r = {c[2:0], c[3]};
    return r;
  endfunction

endpackage

// File: rtl/solar_step_scheduler_step_phase_gen.sv
// Step-rate prescaler and 4-phase coil rotator.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   run         high while a move is in progress; low holds the prescaler at 0
//   dir         0 = forward rotation, 1 = reverse rotation
//   step_en     when low, a step slot still strobes but the coil is not rotated
//   coil        registered coil drive pattern
//   step_strobe high on the cycle whose rising edge completes a step slot
module step_phase_gen
  import solar_pkg::*;
#(
  parameter int         STEP_DIV   = STEP_DIV_DEF,
  parameter logic [3:0] PHASE_INIT = PHASE_INIT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       dir,
  input  logic       step_en,
  output logic [3:0] coil,
  output logic       step_strobe
);

  localparam int                DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] prescaler;

  // The strobe lands on the last prescaler count, so the first step of a
  // move happens STEP_DIV cycles after the move starts.
  assign step_strobe = run && (prescaler == DIV_LAST);

  // Held at zero while idle so every move starts from a clean slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else if (!run || step_strobe) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coil <= PHASE_INIT;
    end else if (step_strobe && step_en) begin
      coil <= rot_coil(coil, dir);
    end
  end

endmodule

// File: rtl/solar_step_scheduler.sv
// Hourly scheduler for the solar panel tilt stepper.
//
// Each hour tick is either processed at once (when idle) or parked in a
// one-deep pending slot (when a move is running). Daytime hours advance the
// panel a fixed number of steps, the return hour drives it back home, and all
// other hours leave it where it is.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   hour_tick   one-cycle pulse per hour
//   enable      permits forward tracking moves (return-to-home ignores it)
//   coil        registered 4-phase stepper drive
//   busy        move in progress
//   dir         1 = returning home, 0 = forward; meaningful while busy
//   hour_idx    hour index the next processed tick will use
//   position    steps from home
//   at_home     position is zero
//   missed_tick one-cycle pulse when a tick is dropped
module solar_step_scheduler
  import solar_pkg::*;
#(
  parameter int         STEPS_PER_HOUR = STEPS_PER_HOUR_DEF,
  parameter int         DAY_HOURS      = DAY_HOURS_DEF,
  parameter int         HOURS_PER_DAY  = HOURS_PER_DAY_DEF,
  parameter int         STEP_DIV       = STEP_DIV_DEF,
  parameter logic [3:0] PHASE_INIT     = PHASE_INIT_DEF,
  localparam int        POS_W          = $clog2(DAY_HOURS * STEPS_PER_HOUR + 1),
  localparam int        HOUR_W         = $clog2(HOURS_PER_DAY)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hour_tick,
  input  logic              enable,
  output logic [3:0]        coil,
  output logic              busy,
  output logic              dir,
  output logic [HOUR_W-1:0] hour_idx,
  output logic [POS_W-1:0]  position,
  output logic              at_home,
  output logic              missed_tick
);

  localparam logic [HOUR_W-1:0] DAY_IDX   = HOUR_W'(DAY_HOURS);
  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(HOURS_PER_DAY - 1);
  localparam logic [POS_W-1:0]  POS_CAP   = POS_W'(DAY_HOURS * STEPS_PER_HOUR);
  localparam logic [POS_W-1:0]  FWD_STEPS = POS_W'(STEPS_PER_HOUR);

  sched_state_t      state;
  logic              pending;
  logic [POS_W-1:0]  remaining;

  logic              idle;
  logic              take;
  logic              drop;
  logic              capture;
  logic              start_fwd;
  logic              start_ret;
  logic              at_cap;
  logic              last_step;
  logic              step_strobe;
  logic              step_en;
  logic [HOUR_W-1:0] hour_next;

  assign idle    = (state == ST_IDLE);
  assign busy    = !idle;
  assign dir     = (state == ST_RET);
  assign at_home = (position == '0);

  // A tick is processed when idle; a pending tick takes priority, so a new
  // tick arriving in that same cycle meets a full slot and is dropped.
  assign take    = idle && (pending || hour_tick);
  assign drop    = hour_tick && pending;
  assign capture = hour_tick && !idle && !pending;

  assign start_fwd = take && (hour_idx < DAY_IDX) && enable;
  assign start_ret = take && (hour_idx == DAY_IDX) && (position != '0);

  assign hour_next = (hour_idx == LAST_HOUR) ? '0 : hour_idx + 1'b1;

  // At the travel limit the remaining forward steps are abandoned: the next
  // step slot ends the move without touching the coil or the position.
  assign at_cap    = (state == ST_FWD) && (position == POS_CAP);
  assign step_en   = !at_cap;
  assign last_step = (remaining == POS_W'(1));

  step_phase_gen #(
    .STEP_DIV   (STEP_DIV),
    .PHASE_INIT (PHASE_INIT)
  ) u_phase (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (busy),
    .dir         (dir),
    .step_en     (step_en),
    .coil        (coil),
    .step_strobe (step_strobe)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      missed_tick <= 1'b0;
    end else begin
      missed_tick <= drop;
      if (take) begin
        pending <= 1'b0;
      end else if (capture) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      hour_idx  <= '0;
      position  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            hour_idx <= hour_next;
            if (start_fwd) begin
              state     <= ST_FWD;
              remaining <= FWD_STEPS;
            end else if (start_ret) begin
              state     <= ST_RET;
              remaining <= position;
            end
          end
        end
        ST_FWD: begin
          if (step_strobe) begin
            if (at_cap) begin
              state <= ST_IDLE;
            end else begin
              position  <= position + 1'b1;
              remaining <= remaining - 1'b1;
              if (last_step) state <= ST_IDLE;
            end
          end
        end
        ST_RET: begin
          if (step_strobe) begin
            position  <= position - 1'b1;
            remaining <= remaining - 1'b1;
            if (last_step) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solar_step_scheduler.sv
module tb_solar_step_scheduler;

  localparam logic [3:0] HOME = 4'b1001;
  localparam int         SD   = 4;

  typedef struct {
    logic en;
    int   busy_cyc;
    logic exp_dir;
    int   exp_pos;
    int   exp_hour;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hour_tick;
  logic       enable;
  logic [3:0] coil;
  logic       busy;
  logic       dir;
  logic [4:0] hour_idx;
  logic [6:0] position;
  logic       at_home;
  logic       missed_tick;

  int         total = 0;
  int         bad = 0;
  int         missed_seen = 0;
  int         cur_pos;
  logic [3:0] cur_coil;
  vec_t       tbl [27];

  solar_step_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hour_tick   (hour_tick),
    .enable      (enable),
    .coil        (coil),
    .busy        (busy),
    .dir         (dir),
    .hour_idx    (hour_idx),
    .position    (position),
    .at_home     (at_home),
    .missed_tick (missed_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && missed_tick === 1'b1) missed_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rot_n(input logic [3:0] c, input int n, input logic rev);
    logic [3:0] r;
    r = c;
    for (int i = 0; i < n; i++) r = rev ? {r[0], r[3:1]} : {r[2:0], r[3]};
    return r;
  endfunction

  // Pulse a tick, then follow the move sample by sample (samples on falling edges).
  task automatic run_row(input vec_t v, input string tag);
    int nb;
    int steps;
    int exp_p;
    enable = v.en;
    @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 1000) begin
      nb++;
      steps = (nb - 1) / SD;
      if (nb == 1) check({tag, "_dir"}, dir, v.exp_dir);
      check({tag, "_coil_mid"}, coil, rot_n(cur_coil, steps, v.exp_dir));
      exp_p = v.exp_dir ? cur_pos - steps : cur_pos + steps;
      check({tag, "_pos_mid"}, position, exp_p);
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, nb, v.busy_cyc);
    check({tag, "_pos"}, position, v.exp_pos);
    check({tag, "_hour"}, hour_idx, v.exp_hour);
    check({tag, "_at_home"}, at_home, int'(v.exp_pos == 0));
    check({tag, "_coil_end"}, coil, rot_n(cur_coil, v.busy_cyc / SD, v.exp_dir));
    check({tag, "_missed"}, missed_tick, 0);
    cur_pos  = v.exp_pos;
    cur_coil = rot_n(cur_coil, v.busy_cyc / SD, v.exp_dir);
  endtask

  task automatic wait_idle(input int limit, output int nb);
    nb = 0;
    while (busy === 1'b1 && nb < limit) begin
      nb++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] seq [4];
    int         n;
    int         g;
    int         m0;

    seq[0] = 4'b1001; seq[1] = 4'b0011; seq[2] = 4'b0110; seq[3] = 4'b1100;

    // Day 1 hours 1..11 forward, hour 12 returns (enable low: return ignores it),
    // hours 13..23 idle, then day 2 hours 0..2 forward and hour 3 disabled.
    for (int h = 1; h <= 11; h++) tbl[h-1] = '{1'b1, 32, 1'b0, 8 * (h + 1), h + 1};
    tbl[11] = '{1'b0, 384, 1'b1, 0, 13};
    for (int h = 13; h <= 23; h++) tbl[h-1] = '{1'b1, 0, 1'b0, 0, (h + 1) % 24};
    tbl[23] = '{1'b1, 32, 1'b0, 8, 1};
    tbl[24] = '{1'b1, 32, 1'b0, 16, 2};
    tbl[25] = '{1'b1, 32, 1'b0, 24, 3};
    tbl[26] = '{1'b0, 0, 1'b0, 24, 4};

    reset_n   = 1'b0;
    hour_tick = 1'b0;
    enable    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_coil", coil, HOME);
    check("rst_busy", busy, 0);
    check("rst_dir", dir, 0);
    check("rst_hour", hour_idx, 0);
    check("rst_pos", position, 0);
    check("rst_at_home", at_home, 1);
    check("rst_missed", missed_tick, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_coil", coil, HOME);

    // First forward move with explicit coil timing.
    enable = 1'b1;
    @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      check($sformatf("fwd0_busy_s%0d", k), busy, int'(k <= 32));
      check($sformatf("fwd0_coil_s%0d", k), coil, seq[((k - 1) / 4) % 4]);
      @(negedge clk);
    end
    check("fwd0_pos", position, 8);
    check("fwd0_hour", hour_idx, 1);
    check("fwd0_at_home", at_home, 0);
    cur_pos  = 8;
    cur_coil = HOME;

    for (int i = 0; i < 27; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Pending slot: second tick waits, third is dropped.
    m0     = missed_seen;
    enable = 1'b1;
    @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    repeat (4) @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    check("pend_hour_a", hour_idx, 5);
    check("pend_busy", busy, 1);
    repeat (3) @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    check("pend_missed_pulse", missed_tick, 1);
    check("pend_hour_b", hour_idx, 5);
    @(negedge clk);
    check("pend_missed_low", missed_tick, 0);
    wait_idle(100, n);
    g = 0;
    while (busy !== 1'b1 && g < 10) begin
      g++;
      @(negedge clk);
    end
    check("pend_gap", g, 1);
    check("pend_hour_c", hour_idx, 6);
    wait_idle(100, n);
    check("pend_pos", position, 40);
    check("pend_hour_d", hour_idx, 6);
    check("pend_missed_count", missed_seen - m0, 1);

    // Tick on the edge where busy falls is parked, then accepted next cycle.
    @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    n = 1;
    while (n < 32) begin
      @(negedge clk);
      n++;
    end
    check("simul_busy_last", busy, 1);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    check("simul_busy_gap", busy, 0);
    check("simul_hour_gap", hour_idx, 7);
    @(negedge clk);
    check("simul_busy_again", busy, 1);
    check("simul_hour_again", hour_idx, 8);
    check("simul_dir", dir, 0);
    wait_idle(100, n);
    check("simul_pos", position, 56);
    cur_pos  = 56;
    cur_coil = coil;
    check("simul_coil", coil, HOME);

    for (int h = 8; h <= 11; h++) run_row('{1'b1, 32, 1'b0, cur_pos + 8, h + 1}, $sformatf("late%0d", h));

    // Reset in the middle of a return move.
    @(negedge clk);
    hour_tick = 1'b1;
    @(negedge clk);
    hour_tick = 1'b0;
    n = 0;
    while (position != 7'd50 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("midret_pos", position, 50);
    check("midret_dir", dir, 1);
    check("midret_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_coil", coil, HOME);
    check("arst_pos", position, 0);
    check("arst_busy", busy, 0);
    check("arst_hour", hour_idx, 0);
    check("arst_at_home", at_home, 1);
    check("arst_dir", dir, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
